// File: rtl/tdm_demux_rx.sv
// Purpose : receive side of a 2:1 bit-serial TDM link; steers each bit to the channel
//           named by din_sel and assembles LSB-first words per channel.
// Latency : a word is presented one clock after its final bit is sampled.
// Backpr. : one-word output register per channel; a word completing while that channel is
//           full and not ready is dropped and flagged in the sticky ovf bit.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   din, din_sel            serial bit and its channel (0 = ch0, 1 = ch1)
//   din_valid, din_sync     bit qualifier; sync marks bit 0 of a new word
//   chN_data/valid/ready    per-channel word output with valid/ready handshake
//   ovf, ovf_clr            sticky per-channel overflow flags and their clear
module tdm_demux_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_sel,
  input  logic             din_valid,
  input  logic             din_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic [1:0]       ovf,
  input  logic             ovf_clr
);

  // Bit counter only has to hold 0..WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  logic [1:0] ready_v;
  logic [1:0] ovf_set_v;
  logic [1:0] ovf_q;

  assign ready_v = {ch1_ready, ch0_ready};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic             hit;
    logic             done;
    logic             load;
    logic             ovf_set;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    pos;
    // The top bit never needs storing: it arrives together with completion and is
    // taken straight from din when the output register loads.
    logic [WIDTH-2:0] shreg_q;
    logic [WIDTH-1:0] data_q;
    ostate_t          state_q;
    ostate_t          state_d;

    assign hit  = din_valid && (din_sel == 1'(c));
    // A sync bit always lands at position 0, abandoning any partial word silently.
    assign pos  = din_sync ? '0 : cnt_q;
    assign done = hit && (pos == CW'(WIDTH - 1));

    // Assembly: shift register and bit counter only move on a bit for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shreg_q <= '0;
        cnt_q   <= '0;
      end else if (hit) begin
        if (!done) begin
          shreg_q[pos] <= din;
        end
        cnt_q <= done ? '0 : pos + CW'(1);
      end
    end

    // Output state machine: next state and load/overflow decisions.
    always_comb begin
      state_d = state_q;
      load    = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
        EMPTY: begin
          if (done) begin
            state_d = FULL;
            load    = 1'b1;
          end
        end
        FULL: begin
          if (done) begin
            // Draining in the same cycle frees the register for the new word;
            // otherwise the held word wins and the new one is lost.
            if (ready_v[c]) begin
              load = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end else if (ready_v[c]) begin
            state_d = EMPTY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        if (load) begin
          data_q <= {din, shreg_q};
        end
      end
    end

    assign ovf_set_v[c] = ovf_set;
  end

  // Sticky overflow flags; a new overflow takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_set_v | (ovf_q & ~{2{ovf_clr}});
    end
  end

  assign ch0_data  = g_ch[0].data_q;
  assign ch0_valid = (g_ch[0].state_q == FULL);
  assign ch1_data  = g_ch[1].data_q;
  assign ch1_valid = (g_ch[1].state_q == FULL);
  assign ovf       = ovf_q;

endmodule
